vga_scan_reader: RTL and testbench
==================================

VGA_SCAN_READER -- requirements
Module: vga_scan_reader

Interface
REQ-001 Parameter X_OFFSET, default 192: first displayed column of the 256x256 window.
REQ-002 Parameter Y_OFFSET, default 112: first displayed line of the 256x256 window.
REQ-003 Clock  input  1  system clock, 50 MHz; all logic is on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 oReadAddress  output  16  video RAM read address: {row[7:0], column[7:0]}.
REQ-006 iReadData  input  8  video RAM pixel in RGB 3-3-2; valid one Clock after oReadAddress changes.
REQ-007 oVGA_Red  output  3  red component.
REQ-008 oVGA_Green  output  3  green component.
REQ-009 oVGA_Blue  output  2  blue component.
REQ-010 oHSync  output  1  horizontal sync, active-low.
REQ-011 oVSync  output  1  vertical sync, active-low.
REQ-012 oFrameStart  output  1  one-Clock pulse at the start of each frame.

Function
REQ-013 The block SHALL generate a pixel enable on every second Clock, giving a 25 MHz pixel rate; all counters advance only on pixel enable.
REQ-014 The horizontal counter (hcount) SHALL count 0..799 and wrap to 0; the vertical counter (vcount) SHALL increment when hcount wraps, count 0..524 and wrap to 0.
REQ-015 Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 Inside the window, X_OFFSET <= hcount < X_OFFSET+256 and Y_OFFSET <= vcount < Y_OFFSET+256, oReadAddress SHALL be {vcount-Y_OFFSET, hcount-X_OFFSET} truncated to 8 bits each.
REQ-018 Outside the window, oReadAddress SHALL hold its last value.
REQ-019 The pipeline is two pixel periods deep: counters, then registered address, then captured data.
REQ-020 oHSync, oVSync and RGB SHALL be delayed two pixel periods so that all three describe the same (hcount, vcount).
REQ-021 For a window pixel, RGB SHALL be iReadData[7:5], iReadData[4:2] and iReadData[1:0].
REQ-022 For any other active pixel, RGB SHALL be 0, except as modified by REQ-030.
REQ-023 During blanking, RGB SHALL be 0.
REQ-024 oFrameStart SHALL be high for exactly one Clock: the pixel-enable Clock on which the counters move to (0,0).
REQ-025 The block has no handshake: memory reads occur every window pixel unconditionally, and the writer side shares a dual-port RAM.

Reset
REQ-026 While Reset is high, the following SHALL be held: hcount=0, vcount=0, pixel-enable phase=0, oReadAddress=0, RGB=0, oHSync=1, oVSync=1, oFrameStart=0.
REQ-027 On Reset deassertion, the first pixel enable SHALL occur on the second Clock.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; the frame restarts at (0,0) with no partial sync pulse.
REQ-029 oFrameStart SHALL NOT pulse on the release of reset itself; it first pulses at the next wrap to (0,0).

Configuration
REQ-030 When macro VGA_BORDER_EN is defined, active pixels at the following positions SHALL output 8'hFF (white):
- hcount = X_OFFSET-1 or X_OFFSET+256, with vcount in Y_OFFSET-1..Y_OFFSET+256;
- vcount = Y_OFFSET-1 or Y_OFFSET+256, with hcount in the same ranges.
REQ-031 When VGA_BORDER_EN is undefined, those pixels SHALL be black, and no border logic SHALL be synthesized.

Verification
REQ-032 Reset release, then run one frame:
- oHSync low for exactly 192 Clocks;
- line period 1600 Clocks;
- oVSync low for 3200 Clocks;
- frame period 840000 Clocks;
- oFrameStart period 840000 Clocks.
REQ-033 RAM model returns data = low byte of address:
- pixel (192,112) outputs RGB 0/0/0 with address 16'h0000;
- pixel (447,367) outputs RGB 7/7/3 with address 16'hFFFF;
- pixel (200,112) outputs data 8'h08.
REQ-034 Pixels (191,112), (448,112), (192,111) and (192,368): RGB=0 without VGA_BORDER_EN and 8'hFF with it; pixel (0,0) is 0 in both builds.
REQ-035 Assert Reset for 3 Clocks at hcount=700, vcount=491 (inside vsync):
- oVSync and oHSync go high and RGB goes 0 asynchronously;
- after release, hcount restarts at 0;
- first oFrameStart occurs 840000 Clocks after the restart.
REQ-036 Sync alignment:
- the falling edge of oHSync at hcount 656 occurs 2 pixel periods after the counter reaches 656;
- RGB is 0 throughout hcount 640..799 and vcount 480..524.

Source files
------------

// File: rtl/vga_scan_reader_if.sv
// vga_scan_reader_if: video RAM read port between the scan reader and the RAM.
// The reader drives the address; the RAM returns the pixel one Clock later.
interface vga_scan_reader_if;
   logic [15:0] oReadAddress;
   logic [7:0]  iReadData;

   modport master (
      output oReadAddress,
      input  iReadData
   );

   modport slave (
      input  oReadAddress,
      output iReadData
   );
endinterface

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480 VGA scan-out of a 256x256 RGB332 window from video RAM.
// Define VGA_BORDER_EN to draw a white one-pixel frame around the window.
module vga_scan_reader #(
   parameter int X_OFFSET = 192,
   parameter int Y_OFFSET = 112
) (
   input  logic              Clock,
   input  logic              Reset,
   vga_scan_reader_if.master ram,
   output logic [2:0]        oVGA_Red,
   output logic [2:0]        oVGA_Green,
   output logic [1:0]        oVGA_Blue,
   output logic              oHSync,
   output logic              oVSync,
   output logic              oFrameStart
);

   localparam logic [9:0] H_ACT  = 10'd640;
   localparam logic [9:0] H_SS   = 10'd656;
   localparam logic [9:0] H_SE   = 10'd751;
   localparam logic [9:0] H_LAST = 10'd799;
   localparam logic [9:0] V_ACT  = 10'd480;
   localparam logic [9:0] V_SS   = 10'd490;
   localparam logic [9:0] V_SE   = 10'd491;
   localparam logic [9:0] V_LAST = 10'd524;

   localparam logic [10:0] XL  = 11'(X_OFFSET);
   localparam logic [10:0] XH  = 11'(X_OFFSET + 256);
   localparam logic [10:0] YL  = 11'(Y_OFFSET);
   localparam logic [10:0] YH  = 11'(Y_OFFSET + 256);
   localparam logic [7:0]  XL8 = 8'(X_OFFSET);
   localparam logic [7:0]  YL8 = 8'(Y_OFFSET);

   logic        phase;
   logic        pix_en;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [10:0] hx;
   logic [10:0] vy;
   logic        in_win;
   logic        active;
   logic        hs;
   logic        vs;
   logic [15:0] addr;
   logic        win_d;
   logic        act_d;
   logic        hs_d;
   logic        vs_d;
   logic [7:0]  pix;
   logic [7:0]  rgb;

   assign pix_en = phase;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) phase <= 1'b0;
      else       phase <= ~phase;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_en) begin
         if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
         end else begin
            hcount <= hcount + 10'd1;
         end
      end
   end

   // Pulses in the Clock right after the counters wrap to (0,0).
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) oFrameStart <= 1'b0;
      else       oFrameStart <= pix_en && hcount == H_LAST && vcount == V_LAST;
   end

   assign hx     = {1'b0, hcount};
   assign vy     = {1'b0, vcount};
   assign in_win = hx >= XL && hx < XH && vy >= YL && vy < YH;
   assign active = hcount < H_ACT && vcount < V_ACT;
   assign hs     = !(hcount >= H_SS && hcount <= H_SE);
   assign vs     = !(vcount >= V_SS && vcount <= V_SE);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         addr  <= '0;
         win_d <= 1'b0;
         act_d <= 1'b0;
         hs_d  <= 1'b1;
         vs_d  <= 1'b1;
      end else if (pix_en) begin
         if (in_win) addr <= {vcount[7:0] - YL8, hcount[7:0] - XL8};
         win_d <= in_win;
         act_d <= active;
         hs_d  <= hs;
         vs_d  <= vs;
      end
   end

`ifdef VGA_BORDER_EN
   localparam logic [10:0] XB = 11'(X_OFFSET - 1);
   localparam logic [10:0] YB = 11'(Y_OFFSET - 1);

   logic in_bx;
   logic in_by;
   logic border;
   logic border_d;

   assign in_bx  = hx >= XB && hx <= XH;
   assign in_by  = vy >= YB && vy <= YH;
   assign border = ((hx == XB || hx == XH) && in_by) ||
                   ((vy == YB || vy == YH) && in_bx);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)       border_d <= 1'b0;
      else if (pix_en) border_d <= border;
   end
`endif

   always_comb begin
      pix = 8'h00;
      if (act_d && win_d) pix = ram.iReadData;
`ifdef VGA_BORDER_EN
      else if (act_d && border_d) pix = 8'hFF;
`endif
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rgb    <= '0;
         oHSync <= 1'b1;
         oVSync <= 1'b1;
      end else if (pix_en) begin
         rgb    <= pix;
         oHSync <= hs_d;
         oVSync <= vs_d;
      end
   end

   assign ram.oReadAddress = addr;
   assign oVGA_Red   = rgb[7:5];
   assign oVGA_Green = rgb[4:2];
   assign oVGA_Blue  = rgb[1:0];

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader: timing, window mapping, border and reset checks
// for vga_scan_reader against a RAM whose data is the address low byte.
`timescale 1ns/1ps
module tb_vga_scan_reader;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [2:0] oVGA_Red;
   logic [2:0] oVGA_Green;
   logic [1:0] oVGA_Blue;
   logic       oHSync;
   logic       oVSync;
   logic       oFrameStart;

   int ncyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      int          q;
      logic [15:0] addr;
      logic [7:0]  rgb;
   } exp_t;

   exp_t sb[$];

`ifdef VGA_BORDER_EN
   localparam logic [7:0] BC = 8'hFF;
`else
   localparam logic [7:0] BC = 8'h00;
`endif

   vga_scan_reader_if ram ();

   vga_scan_reader #(
      .X_OFFSET(192),
      .Y_OFFSET(112)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .ram        (ram),
      .oVGA_Red   (oVGA_Red),
      .oVGA_Green (oVGA_Green),
      .oVGA_Blue  (oVGA_Blue),
      .oHSync     (oHSync),
      .oVSync     (oVSync),
      .oFrameStart(oFrameStart)
   );

   always #10 Clock = ~Clock;

   // Synchronous RAM model: data is the low byte of the address.
   always @(posedge Clock) ram.iReadData <= ram.oReadAddress[7:0];

   // Clocks since reset release; pixel q is on the outputs after edge 2q+4.
   always @(posedge Clock) begin
      if (Reset) ncyc <= 0;
      else       ncyc <= ncyc + 1;
   end

   function automatic logic [7:0] rgb_now();
      return {oVGA_Red, oVGA_Green, oVGA_Blue};
   endfunction

   task automatic wait_cyc(input int n);
      while (ncyc < n) @(negedge Clock);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      checks++;
      if (ram.oReadAddress !== 16'h0000) begin
         errors++;
         $display("FAIL reset_addr: got %h expected 0000", ram.oReadAddress);
      end
      checks++;
      if (rgb_now() !== 8'h00) begin
         errors++;
         $display("FAIL reset_rgb: got %h expected 00", rgb_now());
      end
      checks++;
      if (oHSync !== 1'b1 || oVSync !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync: got h=%b v=%b expected 1 1", oHSync, oVSync);
      end
      checks++;
      if (oFrameStart !== 1'b0) begin
         errors++;
         $display("FAIL reset_fs: got %b expected 0", oFrameStart);
      end
      Reset = 1'b0;
   endtask

   task automatic push(input string nm, input int h, input int v,
                       input logic [15:0] a, input logic [7:0] c);
      exp_t e;
      e.name = nm;
      e.q    = v * 800 + h;
      e.addr = a;
      e.rgb  = c;
      sb.push_back(e);
   endtask

   task automatic test_pixels();
      exp_t e;
      push("px_0_0",     0,   0,   16'h0000, 8'h00);
      push("px_192_111", 192, 111, 16'h0000, BC);
      push("px_191_112", 191, 112, 16'h0000, BC);
      push("px_192_112", 192, 112, 16'h0000, 8'h00);
      push("px_200_112", 200, 112, 16'h0008, 8'h08);
      push("px_448_112", 448, 112, 16'h00FF, BC);
      push("px_447_367", 447, 367, 16'hFFFF, 8'hFF);
      push("px_192_368", 192, 368, 16'hFFFF, BC);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         wait_cyc(2 * e.q + 2);
         checks++;
         if (ram.oReadAddress !== e.addr) begin
            errors++;
            $display("FAIL %s_addr: got %h expected %h",
                     e.name, ram.oReadAddress, e.addr);
         end
         wait_cyc(2 * e.q + 4);
         checks++;
         if (rgb_now() !== e.rgb) begin
            errors++;
            $display("FAIL %s_rgb: got %h expected %h", e.name, rgb_now(), e.rgb);
         end
      end
   endtask

   task automatic test_hsync(input int line);
      int   base;
      int   f1;
      int   r1;
      int   f2;
      logic prev;
      base = 2 * line * 800 + 4;
      f1 = -1;
      r1 = -1;
      f2 = -1;
      wait_cyc(base);
      prev = oHSync;
      while (ncyc < base + 4000 && f2 < 0) begin
         @(negedge Clock);
         if (prev && !oHSync) begin
            if (f1 < 0) f1 = ncyc;
            else        f2 = ncyc;
         end
         if (!prev && oHSync && r1 < 0) r1 = ncyc;
         prev = oHSync;
      end
      checks++;
      if (f1 != 2 * (line * 800 + 656) + 4) begin
         errors++;
         $display("FAIL hsync_align: fell at %0d expected %0d",
                  f1, 2 * (line * 800 + 656) + 4);
      end
      checks++;
      if (r1 - f1 != 192) begin
         errors++;
         $display("FAIL hsync_width: got %0d expected 192", r1 - f1);
      end
      checks++;
      if (f2 - f1 != 1600) begin
         errors++;
         $display("FAIL line_period: got %0d expected 1600", f2 - f1);
      end
   endtask

   task automatic test_blanking(input int line, input int h0);
      int bad;
      bad = 0;
      for (int h = h0; h < 800; h++) begin
         wait_cyc(2 * (line * 800 + h) + 4);
         if (rgb_now() !== 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL blank_line%0d: got %0d lit pixels expected 0", line, bad);
      end
   endtask

   task automatic test_mid_reset();
      int q;
      q = 491 * 800 + 700;
      wait_cyc(2 * q);
      checks++;
      if (oHSync !== 1'b0 || oVSync !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_sync: got h=%b v=%b expected 0 0", oHSync, oVSync);
      end
      #3 Reset = 1'b1;
      #1;
      checks++;
      if (oHSync !== 1'b1 || oVSync !== 1'b1) begin
         errors++;
         $display("FAIL async_sync: got h=%b v=%b expected 1 1", oHSync, oVSync);
      end
      checks++;
      if (rgb_now() !== 8'h00 || ram.oReadAddress !== 16'h0000) begin
         errors++;
         $display("FAIL async_rgb_addr: got %h/%h expected 00/0000",
                  rgb_now(), ram.oReadAddress);
      end
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic test_restart();
      int   hf;
      int   vf;
      int   vlow;
      int   fs1;
      int   fsn;
      logic ph;
      logic pv;
      hf = -1;
      vf = -1;
      vlow = 0;
      fs1 = -1;
      fsn = 0;
      ph = 1'b1;
      pv = 1'b1;
      while (ncyc < 840010) begin
         @(negedge Clock);
         if (ph && !oHSync && hf < 0) hf = ncyc;
         if (pv && !oVSync && vf < 0) vf = ncyc;
         if (!oVSync) vlow++;
         if (oFrameStart) begin
            fsn++;
            if (fs1 < 0) fs1 = ncyc;
         end
         ph = oHSync;
         pv = oVSync;
      end
      checks++;
      if (hf != 1316) begin
         errors++;
         $display("FAIL restart_hsync: fell at %0d expected 1316", hf);
      end
      checks++;
      if (vf != 784004) begin
         errors++;
         $display("FAIL vsync_start: fell at %0d expected 784004", vf);
      end
      checks++;
      if (vlow != 3200) begin
         errors++;
         $display("FAIL vsync_width: got %0d expected 3200", vlow);
      end
      checks++;
      if (fs1 != 840000) begin
         errors++;
         $display("FAIL frame_period: got %0d expected 840000", fs1);
      end
      checks++;
      if (fsn != 1) begin
         errors++;
         $display("FAIL fs_width: got %0d expected 1", fsn);
      end
   endtask

   initial begin
      #40000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_pixels();
      test_hsync(370);
      test_blanking(372, 640);
      for (int v = 480; v < 490; v++) test_blanking(v, 0);
      test_mid_reset();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
